// File: rtl/phoneme_player.sv
// Plays one phoneme: looks up its start/length in the phoneme table, then emits one
// signed PCM sample from the sample ROM for each codec request until the length is used up.
module phoneme_player #(
    parameter int PHONEME_COUNT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_phoneme_output,
    input  logic [7:0]  phoneme_sel,
    input  logic        audio_sample_req,
    output logic [7:0]  tbl_addr,
    input  logic [15:0] tbl_start,
    input  logic [15:0] tbl_len,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic [15:0] audio_out,
    output logic        audio_out_valid,
    output logic        phoneme_speech_busy,
    output logic        phoneme_speech_finish,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        LOAD     = 3'd2,
        WAIT_REQ = 3'd3,
        FETCH    = 3'd4,
        EMIT     = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] addr_cnt;
    logic [15:0] remain_cnt;
    logic [15:0] audio_hold;
    logic [15:0] sample;
    logic        code_ok;

    assign code_ok = ({24'd0, phoneme_sel} < PHONEME_COUNT);

    // Unsigned ROM byte becomes signed PCM by flipping the MSB and scaling to 16 bits.
    assign sample = {rom_data ^ 8'h80, 8'h00};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start_phoneme_output) state_nx = code_ok ? LOOKUP : DONE;
            LOOKUP:   state_nx = LOAD;
            LOAD:     state_nx = (tbl_len == 16'd0) ? DONE : WAIT_REQ;
            WAIT_REQ: if (audio_sample_req) state_nx = FETCH;
            FETCH:    state_nx = EMIT;
            EMIT:     state_nx = (remain_cnt == 16'd1) ? DONE : WAIT_REQ;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // tbl_addr doubles as the latched phoneme code; it is loaded on entry to LOOKUP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tbl_addr   <= 8'd0;
            rom_addr   <= 16'd0;
            addr_cnt   <= 16'd0;
            remain_cnt <= 16'd0;
            audio_hold <= 16'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_phoneme_output && code_ok)
                tbl_addr <= phoneme_sel;
            if (state == LOAD) begin
                addr_cnt   <= tbl_start;
                remain_cnt <= tbl_len;
            end
            if (state == WAIT_REQ && audio_sample_req)
                rom_addr <= addr_cnt;
            if (state == EMIT) begin
                addr_cnt   <= addr_cnt + 16'd1;
                remain_cnt <= remain_cnt - 16'd1;
                audio_hold <= sample;
            end
        end
    end

    // ROM data arrives during EMIT, so the sample is passed straight through that cycle.
    assign audio_out             = (state == EMIT) ? sample : audio_hold;
    assign audio_out_valid       = (state == EMIT);
    assign phoneme_speech_finish = (state == DONE);
    assign phoneme_speech_busy   = (state == LOOKUP) || (state == LOAD) || (state == WAIT_REQ) ||
                                   (state == FETCH) || (state == EMIT);
    assign state_dbg             = state;

endmodule
